tick_mon_wb: RTL
================

TICK_MON_WB -- requirements
Module: tick_mon_wb

Interface
REQ-001 SHALL have parameter E1_N, default 1, number of E1 units monitored (legal 1..2).
REQ-002 SHALL have port clk  input  1  system clock; all logic is in this single domain.
REQ-003 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-004 SHALL have port wb_addr  input  4  word address.
REQ-005 SHALL have port wb_rdata  output  32  read data.
REQ-006 SHALL have port wb_wdata  input  32  write data.
REQ-007 SHALL have port wb_we  input  1  write enable.
REQ-008 SHALL have port wb_cyc  input  1  cycle request, held high until ack.
REQ-009 SHALL have port wb_ack  output  1  one-cycle acknowledge.
REQ-010 SHALL have port tick_e1  input  4*E1_N  per-unit event strobes, 4 per unit, bit 4*u+k = unit u, source k.
REQ-011 SHALL have port tick_usb_sof  input  1  USB start-of-frame strobe, already in clk domain.
REQ-012 SHALL have port snap_stb  output  1  one-cycle pulse each time a snapshot is taken.

Function
REQ-013 SHALL be a Wishbone responder: wb_ack = 1 for exactly one cycle, in the cycle after wb_cyc is sampled high with wb_ack low; no back-to-back ack within one transaction.
REQ-014 SHALL drive wb_rdata = 0 in every cycle where wb_ack = 0 (bus data is OR-combined).
REQ-015 SHALL register read data so that it is valid in the ack cycle and reflects register state at the cycle wb_cyc was sampled.
REQ-016 SHALL apply writes on the clock edge that ends the ack cycle; wb_we ignored when wb_cyc low.
REQ-017 SHALL implement address map: 0 CSR (rw); 1 TIME live (ro; write = clear all); 2 TIME snapshot (ro); 3 SOF count [15:0] (ro); 4..11 snapshot E1 counter index n = addr-4, unit n/4, source n%4; 12..15 read 0, writes ignored.
REQ-018 SHALL define CSR: bit0 EN, bit1 SNAP_EN, bits[9:8] read-only E1_N, all others read 0.
REQ-019 SHALL increment TIME (32-bit) every cycle EN = 1, wrapping 0xFFFFFFFF -> 0.
REQ-020 SHALL increment SOF count (16-bit) on each tick_usb_sof while EN = 1, wrapping modulo 2^16.
REQ-021 SHALL increment live E1 counter (16-bit) for bit i of tick_e1 when that bit is high and EN = 1, wrapping modulo 2^16; simultaneous ticks on different bits each count.
REQ-022 SHALL, on tick_usb_sof with SNAP_EN = 1, copy TIME and all live E1 counters into snapshot registers, capturing pre-increment values of that cycle; snap_stb pulses the following cycle.
REQ-023 SHALL return 0 for snapshot indices whose unit >= E1_N.
REQ-024 SHALL, on write to address 1, zero TIME, SOF count, live and snapshot counters; clear takes priority over any same-cycle increment or snapshot.
REQ-025 SHALL freeze all counters (hold value) while EN = 0; snapshots still occur if SNAP_EN = 1.
REQ-026 SHALL treat a write to CSR in the same cycle as a tick using the old EN for that cycle.

Reset
REQ-027 SHALL on rst asynchronously set wb_ack = 0, wb_rdata = 0, snap_stb = 0, EN = 0, SNAP_EN = 0, all counters and snapshots = 0.
REQ-028 SHALL ignore any transaction in progress at reset; after release the next wb_cyc-high cycle starts a fresh transaction.

Verification
REQ-029 SHALL pass: write CSR=0x1, wait 100 cycles, read addr 1 -> value in 100..104 range matching exact bench model, addr 3 = 0.
REQ-030 SHALL pass: EN=1,SNAP_EN=1, pulse tick_e1[2] 5 times then tick_usb_sof -> addr 6 reads 5, addr 3 reads 1, snap_stb one pulse.
REQ-031 SHALL pass: tick_e1[0] and tick_usb_sof in same cycle after 3 prior ticks -> addr 4 snapshot reads 3, next SOF snapshot reads 4.
REQ-032 SHALL pass: preload SOF count to 0xFFFF via 65535 SOFs, one more SOF -> addr 3 reads 0x0000.
REQ-033 SHALL pass: write addr 1 concurrent with tick_e1 and SOF -> all reads 0; E1_N=1 read addr 8 -> 0; idle rdata always 0.
REQ-034 SHALL pass: assert rst mid-transaction with wb_cyc high -> wb_ack low immediately, CSR reads 0x00000100 after release.

Source files
------------

// File: rtl/tick_mon_wb.sv
// Event/tick monitor with a Wishbone register port: free-running TIME, USB SOF count,
// per-unit E1 event counters, and SOF-triggered snapshots of TIME and the E1 counters.
module tick_mon_wb #(
    parameter int E1_N = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        wb_addr,
    output logic [31:0]       wb_rdata,
    input  logic [31:0]       wb_wdata,
    input  logic              wb_we,
    input  logic              wb_cyc,
    output logic              wb_ack,
    input  logic [4*E1_N-1:0] tick_e1,
    input  logic              tick_usb_sof,
    output logic              snap_stb
);

    localparam int NCNT = 4 * E1_N;

    logic                  ack_q, ack_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  snap_stb_q, snap_stb_d;
    logic                  en_q, en_d;
    logic                  snap_en_q, snap_en_d;
    logic [31:0]           time_q, time_d;
    logic [31:0]           time_snap_q, time_snap_d;
    logic [15:0]           sof_cnt_q, sof_cnt_d;
    logic [NCNT-1:0][15:0] e1_live_q, e1_live_d;
    logic [NCNT-1:0][15:0] e1_snap_q, e1_snap_d;

    logic        req, wr, clr, csr_wr, snap;
    logic [31:0] rd_val;
    logic        wdata_unused;

    // Only the CSR enable bits carry meaning; a write to TIME clears regardless of data.
    assign wdata_unused = ^wb_wdata[31:2];

    // Bus handshake: a request is a cycle with wb_cyc high and no ack outstanding; ack
    // follows one cycle later, and a write takes effect on the edge closing the ack cycle.
    always_comb begin
        req    = wb_cyc & ~ack_q;
        wr     = wb_cyc & ack_q & wb_we;
        clr    = wr && (wb_addr == 4'd1);
        csr_wr = wr && (wb_addr == 4'd0);
        snap   = tick_usb_sof & snap_en_q;

        rd_val = '0;
        case (wb_addr)
            4'd0:    rd_val = {22'b0, 2'(E1_N), 6'b0, snap_en_q, en_q};
            4'd1:    rd_val = time_q;
            4'd2:    rd_val = time_snap_q;
            4'd3:    rd_val = {16'b0, sof_cnt_q};
            default: begin
                for (int i = 0; i < NCNT; i++) begin
                    if (wb_addr == 4'(4 + i)) rd_val = {16'b0, e1_snap_q[i]};
                end
            end
        endcase

        ack_d   = req;
        rdata_d = req ? rd_val : 32'b0;

        en_d      = csr_wr ? wb_wdata[0] : en_q;
        snap_en_d = csr_wr ? wb_wdata[1] : snap_en_q;

        // Increments and snapshots both look at the EN/SNAP_EN in force before any CSR write.
        time_d      = en_q ? time_q + 32'd1 : time_q;
        sof_cnt_d   = (en_q && tick_usb_sof) ? sof_cnt_q + 16'd1 : sof_cnt_q;
        time_snap_d = snap ? time_q : time_snap_q;
        e1_live_d   = e1_live_q;
        e1_snap_d   = snap ? e1_live_q : e1_snap_q;
        for (int i = 0; i < NCNT; i++) begin
            if (en_q && tick_e1[i]) e1_live_d[i] = e1_live_q[i] + 16'd1;
        end
        snap_stb_d = snap;

        // Clear wins over any same-cycle increment or snapshot.
        if (clr) begin
            time_d      = '0;
            sof_cnt_d   = '0;
            time_snap_d = '0;
            e1_live_d   = '0;
            e1_snap_d   = '0;
            snap_stb_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            snap_stb_q  <= 1'b0;
            en_q        <= 1'b0;
            snap_en_q   <= 1'b0;
            time_q      <= '0;
            time_snap_q <= '0;
            sof_cnt_q   <= '0;
            e1_live_q   <= '0;
            e1_snap_q   <= '0;
        end else begin
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            snap_stb_q  <= snap_stb_d;
            en_q        <= en_d;
            snap_en_q   <= snap_en_d;
            time_q      <= time_d;
            time_snap_q <= time_snap_d;
            sof_cnt_q   <= sof_cnt_d;
            e1_live_q   <= e1_live_d;
            e1_snap_q   <= e1_snap_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_rdata = rdata_q;
    assign snap_stb = snap_stb_q;

endmodule
